// File: rtl/rt_rgu_stream.sv
// rt_rgu_stream: streaming primary-ray generator.
// Raster-scans an img_w x img_h frame and emits one ray (origin, direction)
// per pixel over a valid/ready stream at up to one beat per clock. Pixel
// positions are built by incremental accumulation of delta_u / delta_v, so
// no multipliers are needed. All coordinate arithmetic wraps mod 2**W.
`timescale 1ns/1ps

module rt_rgu_stream #(
    parameter int IW = 8,
    parameter int QW = 16,
    parameter int XW = 11,
    parameter int YW = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [XW-1:0]    img_w,
    input  logic [YW-1:0]    img_h,
    input  logic [IW+QW-1:0] cam_center [3],
    input  logic [IW+QW-1:0] pixel00 [3],
    input  logic [IW+QW-1:0] delta_u [3],
    input  logic [IW+QW-1:0] delta_v [3],
    output logic             busy,
    output logic             done,
    output logic             ray_valid,
    input  logic             ray_ready,
    output logic [XW-1:0]    ray_x,
    output logic [YW-1:0]    ray_y,
    output logic             ray_last,
    output logic [IW+QW-1:0] ray_origin [3],
    output logic [IW+QW-1:0] ray_direction [3]
);

    localparam int W = IW + QW;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state, state_nx;
    logic          load;      // accept a start with a non-empty frame
    logic          advance;   // current beat handed off downstream

    // Frame parameters captured on start; inputs are free to change afterwards.
    logic [XW-1:0] w_l;
    logic [YW-1:0] h_l;
    logic [W-1:0]  du_l [3];
    logic [W-1:0]  dv_l [3];

    // row: world position of column 0 on the current row.
    // cur: world position of the pixel currently presented on the stream.
    logic [W-1:0]  row [3];
    logic [W-1:0]  cur [3];

    // Successor pixel of the beat currently on the stream.
    logic          row_end;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic          nxt_last;
    logic [W-1:0]  nxt_pos [3];

    assign busy = (state == RUN);
    assign done = (state == FIN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, independent of block order.
            state <= state_nx;
        end
    end

    // Next-state decode; abort overrides everything, including a handshake.
    always_comb begin
        // NOTE: every output gets a default up front so no path leaves one unassigned (no latch).
        state_nx = state;
        load     = 1'b0;
        advance  = 1'b0;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (img_w != '0 && img_h != '0) begin
                            load     = 1'b1;
                            state_nx = RUN;
                        end else begin
                            state_nx = FIN;
                        end
                    end
                end
                RUN: begin
                    if (ray_valid && ray_ready) begin
                        advance = 1'b1;
                        if (ray_last) state_nx = FIN;
                    end
                end
                FIN:     state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Successor pixel: step along the row, or wrap to the start of the next row.
    always_comb begin
        row_end  = (ray_x == w_l - XW'(1));
        nx       = row_end ? '0 : ray_x + XW'(1);
        ny       = row_end ? ray_y + YW'(1) : ray_y;
        nxt_last = (nx == w_l - XW'(1)) && (ny == h_l - YW'(1));
        for (int i = 0; i < 3; i++) begin
            nxt_pos[i] = row_end ? row[i] + dv_l[i] : cur[i] + du_l[i];
        end
    end

    // Parameter capture, accumulators and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the small parameter/accumulator arrays are reset too, so nothing stale is visible.
            w_l       <= '0;
            h_l       <= '0;
            ray_valid <= 1'b0;
            ray_x     <= '0;
            ray_y     <= '0;
            ray_last  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                du_l[i]          <= '0;
                dv_l[i]          <= '0;
                row[i]           <= '0;
                cur[i]           <= '0;
                ray_origin[i]    <= '0;
                ray_direction[i] <= '0;
            end
        end else if (abort) begin
            ray_valid <= 1'b0;
        end else if (load) begin
            w_l       <= img_w;
            h_l       <= img_h;
            ray_valid <= 1'b1;
            ray_x     <= '0;
            ray_y     <= '0;
            ray_last  <= (img_w == XW'(1)) && (img_h == YW'(1));
            for (int i = 0; i < 3; i++) begin
                du_l[i]          <= delta_u[i];
                dv_l[i]          <= delta_v[i];
                row[i]           <= pixel00[i];
                cur[i]           <= pixel00[i];
                ray_origin[i]    <= cam_center[i];
                ray_direction[i] <= pixel00[i] - cam_center[i];
            end
        end else if (advance) begin
            if (ray_last) begin
                ray_valid <= 1'b0;
            end else begin
                ray_x    <= nx;
                ray_y    <= ny;
                ray_last <= nxt_last;
                for (int i = 0; i < 3; i++) begin
                    if (row_end) row[i] <= nxt_pos[i];
                    cur[i]           <= nxt_pos[i];
                    ray_direction[i] <= nxt_pos[i] - ray_origin[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_rt_rgu_stream.sv
// tb_rt_rgu_stream: scoreboard bench for rt_rgu_stream.
// The driver computes every expected beat from the closed form
// pixel00 + x*du + y*dv - center (mod 2**W) and queues it; a monitor on the
// falling edge compares each presented beat against the queue head and pops
// it only on an accepted handshake.
`timescale 1ns/1ps

module tb_rt_rgu_stream;

    localparam int IW = 8;
    localparam int QW = 16;
    localparam int W  = IW + QW;
    localparam int XW = 11;
    localparam int YW = 11;

    typedef logic [2:0][W-1:0] vec3_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          last;
        vec3_t         org;
        vec3_t         dir;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [XW-1:0] img_w;
    logic [YW-1:0] img_h;
    logic [W-1:0]  cam_center [3];
    logic [W-1:0]  pixel00 [3];
    logic [W-1:0]  delta_u [3];
    logic [W-1:0]  delta_v [3];
    logic          busy;
    logic          done;
    logic          ray_valid;
    logic          ray_ready;
    logic [XW-1:0] ray_x;
    logic [YW-1:0] ray_y;
    logic          ray_last;
    logic [W-1:0]  ray_origin [3];
    logic [W-1:0]  ray_direction [3];

    rt_rgu_stream #(.IW(IW), .QW(QW), .XW(XW), .YW(YW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .img_w         (img_w),
        .img_h         (img_h),
        .cam_center    (cam_center),
        .pixel00       (pixel00),
        .delta_u       (delta_u),
        .delta_v       (delta_v),
        .busy          (busy),
        .done          (done),
        .ray_valid     (ray_valid),
        .ray_ready     (ray_ready),
        .ray_x         (ray_x),
        .ray_y         (ray_y),
        .ray_last      (ray_last),
        .ray_origin    (ray_origin),
        .ray_direction (ray_direction)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t exp_q[$];
    int    done_seen    = 0;
    int    busy_seen    = 0;
    int    valid_cycles = 0;
    int    accepted     = 0;
    int    done_base    = 0;
    bit    ready_rand   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    // Downstream backpressure: always ready, or a 50% coin flip per cycle.
    initial begin
        ray_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ray_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] outs_vec();
        return 256'({ray_valid, busy, done, ray_last, ray_x, ray_y,
                     ray_origin[0], ray_origin[1], ray_origin[2],
                     ray_direction[0], ray_direction[1], ray_direction[2]});
    endfunction

    // Monitor: compare every presented beat with the scoreboard head.
    always @(negedge clk) begin
        beat_t got;
        if (rst_n) begin
            if (ray_valid) begin
                valid_cycles++;
                got.x    = ray_x;
                got.y    = ray_y;
                got.last = ray_last;
                for (int i = 0; i < 3; i++) begin
                    got.org[i] = ray_origin[i];
                    got.dir[i] = ray_direction[i];
                end
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got beat x=%0d y=%0d, required no beat", ray_x, ray_y);
                end else begin
                    check($sformatf("beat_x%0d_y%0d", exp_q[0].x, exp_q[0].y), 256'(got), 256'(exp_q[0]));
                    if (ray_ready && !abort) begin
                        void'(exp_q.pop_front());
                        accepted++;
                    end
                end
            end
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec3_t rand_vec();
        vec3_t v;
        for (int i = 0; i < 3; i++) v[i] = W'($urandom);
        return v;
    endfunction

    // Reference model: every pixel of the frame from the closed form, raster order.
    task automatic push_frame(input int w, input int h, input vec3_t p, input vec3_t du,
                              input vec3_t dv, input vec3_t c);
        beat_t           b;
        longint unsigned t;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                b.x    = XW'(xx);
                b.y    = YW'(yy);
                b.last = (xx == w - 1) && (yy == h - 1);
                for (int i = 0; i < 3; i++) begin
                    t = longint'(p[i]) + longint'(xx) * longint'(du[i])
                      + longint'(yy) * longint'(dv[i]) - longint'(c[i]);
                    b.org[i] = c[i];
                    b.dir[i] = t[W-1:0];
                end
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic set_params(input int w, input int h, input vec3_t p, input vec3_t du,
                              input vec3_t dv, input vec3_t c);
        img_w = XW'(w);
        img_h = YW'(h);
        for (int i = 0; i < 3; i++) begin
            pixel00[i]    = p[i];
            delta_u[i]    = du[i];
            delta_v[i]    = dv[i];
            cam_center[i] = c[i];
        end
    endtask

    task automatic scramble();
        set_params(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                   rand_vec(), rand_vec(), rand_vec(), rand_vec());
    endtask

    // Pulse start for one edge, then garble the parameter inputs.
    task automatic start_frame(input int w, input int h, input vec3_t p, input vec3_t du,
                               input vec3_t dv, input vec3_t c);
        set_params(w, h, p, du, dv, c);
        if (w != 0 && h != 0) push_frame(w, h, p, du, dv, c);
        done_base = done_seen;
        start = 1'b1;
        step();
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (done_seen == done_base && cyc < 500) begin
            step();
            cyc++;
        end
        check({name, "_done_seen"}, 256'(done_seen != done_base), 256'(1));
        check({name, "_drained"}, 256'(exp_q.size()), 256'(0));
        step();
        step();
        check({name, "_done_once"}, 256'(done_seen - done_base), 256'(1));
        check({name, "_idle"}, 256'({busy, ray_valid}), 256'(0));
        exp_q.delete();
    endtask

    initial begin
        vec3_t p1, du1, dv1, c0, pr, dur, dvr, cr;
        int    d0, v0, b0, a0, w, h;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_params(0, 0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs_vec(), 256'(0));
        rst_n = 1'b1;
        step();
        check("idle_after_reset", outs_vec(), 256'(0));

        p1  = '0; du1 = '0; dv1 = '0; c0 = '0;
        p1[0]  = 24'h010000;
        p1[1]  = 24'h020000;
        p1[2]  = 24'h030000;
        du1[0] = 24'h008000;
        dv1[1] = 24'hFF8000;

        // T1: 3x2, always ready: six beats on consecutive clocks, done right after.
        ready_rand = 1'b0;
        a0 = accepted;
        start_frame(3, 2, p1, du1, dv1, c0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t1_valid_%0d", i), 256'({ray_valid, busy}), 256'(2'b11));
            step();
        end
        check("t1_done_cycle", 256'({done, ray_valid}), 256'(2'b10));
        wait_done("t1");
        check("t1_accepted", 256'(accepted - a0), 256'(6));

        // T2: same frame under random backpressure, with a start pulse mid-frame.
        ready_rand = 1'b1;
        a0 = accepted;
        start_frame(3, 2, p1, du1, dv1, c0);
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t2");
        check("t2_accepted", 256'(accepted - a0), 256'(6));

        // T3: empty frames (zero width, then zero height): done only.
        for (int k = 0; k < 2; k++) begin
            d0 = done_seen; v0 = valid_cycles; b0 = busy_seen;
            start_frame(k == 0 ? 0 : 4, k == 0 ? 3 : 0, p1, du1, dv1, c0);
            check($sformatf("t3_%0d_done_timing", k), 256'(done), 256'(1));
            step();
            step();
            check($sformatf("t3_%0d_done_count", k), 256'(done_seen - d0), 256'(1));
            check($sformatf("t3_%0d_no_valid", k), 256'(valid_cycles - v0), 256'(0));
            check($sformatf("t3_%0d_no_busy", k), 256'(busy_seen - b0), 256'(0));
        end

        // Abort together with start in IDLE: abort wins.
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_idle", 256'({busy, ray_valid, done}), 256'(0));

        // T4: abort on the third beat while ready, then replay from (0,0).
        ready_rand = 1'b0;
        start_frame(3, 2, p1, du1, dv1, c0);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_valid_dropped", 256'({busy, ray_valid}), 256'(0));
        check("t4_popped_two", 256'(exp_q.size()), 256'(4));
        exp_q.delete();
        d0 = done_seen;
        step();
        step();
        check("t4_no_done", 256'(done_seen - d0), 256'(0));
        start_frame(3, 2, p1, du1, dv1, c0);
        wait_done("t4_replay");

        // T5: maximal positive column step on a 4x1 frame; directions wrap.
        ready_rand = 1'b1;
        dur = '0;
        for (int i = 0; i < 3; i++) dur[i] = 24'h7FFFFF;
        a0 = accepted;
        start_frame(4, 1, rand_vec(), dur, rand_vec(), rand_vec());
        wait_done("t5");
        check("t5_accepted", 256'(accepted - a0), 256'(4));

        // Single-pixel frame: the first beat is also the last.
        start_frame(1, 1, rand_vec(), rand_vec(), rand_vec(), rand_vec());
        wait_done("one_pixel");

        // Random frames under random backpressure.
        for (int k = 0; k < 8; k++) begin
            w = int'($urandom_range(1, 5));
            h = int'($urandom_range(1, 4));
            a0 = accepted;
            start_frame(w, h, rand_vec(), rand_vec(), rand_vec(), rand_vec());
            wait_done($sformatf("rand%0d", k));
            check($sformatf("rand%0d_accepted", k), 256'(accepted - a0), 256'(w * h));
        end

        // T6: reset mid-frame with start held through and after reset.
        ready_rand = 1'b0;
        start_frame(3, 2, p1, du1, dv1, c0);
        step();
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        check("t6_reset_outputs", outs_vec(), 256'(0));
        exp_q.delete();
        d0 = done_seen;
        pr = rand_vec(); dur = rand_vec(); dvr = rand_vec(); cr = rand_vec();
        set_params(3, 2, pr, dur, dvr, cr);
        step();
        check("t6_held_in_reset", outs_vec(), 256'(0));
        rst_n = 1'b1;
        check("t6_no_done", 256'(done_seen - d0), 256'(0));
        push_frame(3, 2, pr, dur, dvr, cr);
        done_base = done_seen;
        step();
        start = 1'b0;
        scramble();
        check("t6_first_beat", 256'({ray_valid, ray_x, ray_y}), 256'({1'b1, XW'(0), YW'(0)}));
        wait_done("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
